fm_discriminator: RTL and testbench

//  Parametrised FM phase discriminator on AXI-Stream. Consumes CORDIC {angle,magnitude} beats and

---
 rtl/fm_demod_pkg.sv | 19 +
 rtl/fm_discriminator_decim_accum.sv | 52 +++++
 rtl/fm_discriminator.sv | 139 +++++++++++++
 tb/tb_fm_discriminator.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_demod_pkg.sv
// Shared types for the FM/AM demodulator slice.
//   mode_t  : output mode select (DISCRIM_ALT behaves as DISCRIM)
//   angle_t : unsigned CORDIC angle, 2^16 codes per turn
//   diff_t  : signed wrapped phase difference, [-pi, pi)
package fm_demod_pkg;

  typedef enum logic [1:0] {
    DISCRIM     = 2'd0,
    RAW_ANGLE   = 2'd1,
    RAMP        = 2'd2,
    DISCRIM_ALT = 2'd3
  } mode_t;

  localparam int unsigned ANGLE_W_DEFAULT = 16;

  typedef logic        [ANGLE_W_DEFAULT-1:0] angle_t;
  typedef logic signed [ANGLE_W_DEFAULT-1:0] diff_t;

endpackage

// File: rtl/fm_discriminator_decim_accum.sv
// decim_accum: signed accumulate-and-dump over groups of 2^DECIM_LOG2 samples.
// A group also closes early when early_close is set on an accepted sample.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   in_valid     sample accepted this cycle
//   in_data      signed sample
//   early_close  close the group on this sample (e.g. end of packet)
//   close        this sample closes the group (combinational)
//   sum          accumulator plus current sample (combinational)
//   grp_cnt      samples already accumulated in the open group
module decim_accum #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned DECIM_LOG2 = 2
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         in_valid,
  input  logic signed [DATA_W-1:0]                     in_data,
  input  logic                                         early_close,
  output logic                                         close,
  output logic signed [DATA_W+DECIM_LOG2-1:0]          sum,
  output logic [((DECIM_LOG2 > 0) ? DECIM_LOG2 : 1)-1:0] grp_cnt
);

  localparam int unsigned SUM_W = DATA_W + DECIM_LOG2;
  localparam int unsigned CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << DECIM_LOG2) - 1);

  // Wide enough for 2^DECIM_LOG2 full-scale samples, so it cannot overflow.
  logic signed [SUM_W-1:0] acc;

  always_comb begin
    sum   = acc + SUM_W'(in_data);
    close = early_close || (grp_cnt == LAST_CNT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      grp_cnt <= '0;
    end else if (in_valid) begin
      if (close) begin
        acc     <= '0;
        grp_cnt <= '0;
      end else begin
        acc     <= sum;
        grp_cnt <= grp_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fm_discriminator.sv
// fm_discriminator: FM phase discriminator on AXI-Stream.
// Takes CORDIC {angle, magnitude} beats, forms the wrapped phase difference
// between consecutive samples, integrates and decimates by 2^DECIM_LOG2,
// and emits one signed, sign-extended result per group.
// Ports:
//   s00_axis_*   input stream; angle in the top ANGLE_W bits, rest ignored
//   mode         0 DISCRIM, 1 RAW_ANGLE, 2 RAMP, 3 DISCRIM
//   m00_axis_*   output stream, single register stage, tstrb all ones when valid
module fm_discriminator
  import fm_demod_pkg::*;
#(
  parameter int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int unsigned ANGLE_W                = 16,
  parameter int unsigned DECIM_LOG2             = 2,
  parameter int unsigned GAIN_SHIFT             = 1
) (
  input  logic                                  s00_axis_aclk,
  input  logic                                  s00_axis_aresetn,
  input  logic                                  s00_axis_tvalid,
  output logic                                  s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
  input  logic [(C_S00_AXIS_TDATA_WIDTH/8)-1:0] s00_axis_tstrb,
  input  logic                                  s00_axis_tlast,
  input  logic [1:0]                            mode,
  output logic                                  m00_axis_tvalid,
  input  logic                                  m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [(C_M00_AXIS_TDATA_WIDTH/8)-1:0] m00_axis_tstrb,
  output logic                                  m00_axis_tlast
);

  localparam int unsigned SUM_W = ANGLE_W + DECIM_LOG2;
  localparam int unsigned CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int unsigned SHIFT = DECIM_LOG2 + GAIN_SHIFT;
  localparam int unsigned EXT_A = C_M00_AXIS_TDATA_WIDTH - ANGLE_W;
  localparam int unsigned EXT_S = C_M00_AXIS_TDATA_WIDTH - SUM_W;

  logic                                accept;
  logic [ANGLE_W-1:0]                  angle;
  logic [ANGLE_W-1:0]                  prev_angle;
  logic                                prime;
  logic signed [ANGLE_W-1:0]           diff;
  logic                                grp_close;
  logic signed [SUM_W-1:0]             grp_sum;
  logic signed [SUM_W-1:0]             grp_scaled;
  logic [CNT_W-1:0]                    grp_cnt;
  mode_t                               mode_q;
  mode_t                               mode_eff;
  logic [ANGLE_W-1:0]                  ramp;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0]   result;
  logic                                unused_inputs;

  assign unused_inputs = ^{s00_axis_tstrb, s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-ANGLE_W-1:0]};

  // Backpressure depends only on the output register, never on input data.
  assign s00_axis_tready = !m00_axis_tvalid || m00_axis_tready;
  assign accept          = s00_axis_tvalid && s00_axis_tready;
  assign angle           = s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1 -: ANGLE_W];

  // Modular subtraction read as signed gives the shortest-path phase step.
  always_comb begin
    diff = '0;
    if (prime) begin
      diff = angle - prev_angle;
    end
  end

  decim_accum #(
    .DATA_W    (ANGLE_W),
    .DECIM_LOG2(DECIM_LOG2)
  ) u_decim_accum (
    .clk        (s00_axis_aclk),
    .rst_n      (s00_axis_aresetn),
    .in_valid   (accept),
    .in_data    (diff),
    .early_close(s00_axis_tlast),
    .close      (grp_close),
    .sum        (grp_sum),
    .grp_cnt    (grp_cnt)
  );

  // Mode is taken live on the first beat of a group and held in mode_q for
  // the rest of it, so a mid-group change only affects the next group.
  always_comb begin
    mode_eff   = (grp_cnt == '0) ? mode_t'(mode) : mode_q;
    grp_scaled = grp_sum >>> SHIFT;
    case (mode_eff)
      RAW_ANGLE: result = {{EXT_A{angle[ANGLE_W-1]}}, angle};
      RAMP:      result = {{EXT_A{ramp[ANGLE_W-1]}}, ramp};
      default:   result = {{EXT_S{grp_scaled[SUM_W-1]}}, grp_scaled};
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      prev_angle <= '0;
      prime      <= 1'b0;
    end else if (accept) begin
      prev_angle <= angle;
      prime      <= 1'b1;
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      mode_q <= DISCRIM;
    end else if (grp_cnt == '0) begin
      mode_q <= mode_t'(mode);
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      ramp <= '0;
    end else if (accept && grp_close && (mode_eff == RAMP)) begin
      ramp <= ramp + ANGLE_W'(1);
    end
  end

  // A closing push wins over a pop, giving back-to-back output without a bubble.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tstrb  <= '0;
      m00_axis_tlast  <= 1'b0;
    end else if (accept && grp_close) begin
      m00_axis_tvalid <= 1'b1;
      m00_axis_tdata  <= result;
      m00_axis_tstrb  <= '1;
      m00_axis_tlast  <= s00_axis_tlast;
    end else if (m00_axis_tready) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tstrb  <= '0;
    end
  end

endmodule

// File: tb/tb_fm_discriminator.sv
module tb_fm_discriminator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic [3:0]  s_tstrb;
  logic        s_tlast;
  logic [1:0]  mode;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;
  logic        m_tlast;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_data[$];
  logic        exp_last[$];
  logic [31:0] got_data[$];
  logic        got_last[$];

  // Reference model state (group-level arithmetic on integers)
  int prev_a;
  int gsum;
  int glen;
  int gmode;
  int ramp_ref;
  bit primed;

  always #5 clk = ~clk;

  fm_discriminator #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(32),
    .ANGLE_W               (16),
    .DECIM_LOG2            (2),
    .GAIN_SHIFT            (1)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tready (s_tready),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tstrb  (s_tstrb),
    .s00_axis_tlast  (s_tlast),
    .mode            (mode),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tready (m_tready),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tstrb  (m_tstrb),
    .m00_axis_tlast  (m_tlast)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int wrap16(input int d);
    int r;
    r = ((d % 65536) + 65536) % 65536;
    if (r >= 32768) r -= 65536;
    return r;
  endfunction

  function automatic int sext16(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  task automatic model_reset();
    primed   = 0;
    prev_a   = 0;
    gsum     = 0;
    glen     = 0;
    ramp_ref = 0;
  endtask

  task automatic model_beat(input int a, input bit last, input int md);
    int d;
    int r;
    d = primed ? wrap16(a - prev_a) : 0;
    if (glen == 0) gmode = md;
    gsum += d;
    glen++;
    if (glen == 4 || last) begin
      case (gmode)
        1: r = sext16(a);
        2: begin
          r = sext16(ramp_ref);
          ramp_ref = (ramp_ref + 1) % 65536;
        end
        default: r = (gsum >= 0) ? gsum / 8 : -((-gsum + 7) / 8);
      endcase
      exp_data.push_back(32'(r));
      exp_last.push_back(last);
      gsum = 0;
      glen = 0;
    end
    prev_a = a;
    primed = 1;
  endtask

  // Output monitor: records every handshake, sampled between active edges.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      got_data.push_back(m_tdata);
      got_last.push_back(m_tlast);
      check("tstrb_on_valid", 32'(m_tstrb), 32'hF);
    end
  end

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send(input int a, input bit last, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    s_tdata  = {a[15:0], 16'($urandom)};
    s_tstrb  = 4'($urandom);
    s_tlast  = last;
    s_tvalid = 1'b1;
    n = 0;
    while (!s_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) begin
      check("s_ready_timeout", 32'(s_tready), 32'd1);
    end else begin
      @(negedge clk);
      model_beat(a, last, int'(mode));
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic flush(input string tag);
    int n;
    repeat (4) @(negedge clk);
    check({tag, "_count"}, 32'(got_data.size()), 32'(exp_data.size()));
    n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_data"}, got_data[i], exp_data[i]);
      check({tag, "_last"}, 32'(got_last[i]), 32'(exp_last[i]));
    end
    got_data.delete();
    got_last.delete();
    exp_data.delete();
    exp_last.delete();
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tstrb  = '0;
    s_tlast  = 1'b0;
    mode     = 2'd0;
    m_tready = 1'b1;
    model_reset();
    gmode = 0;

    // Reset state
    #1;
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_tstrb", 32'(m_tstrb), 32'd0);
    check("rst_sready", 32'(s_tready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: linear phase ramp in DISCRIM
    for (int k = 0; k < 12; k++) send(k * 32'h1000, 1'b0, 0);
    repeat (4) @(negedge clk);
    check("t1_first", got_data[0], 32'h0000_0600);
    check("t1_second", got_data[1], 32'h0000_0800);
    flush("t1");

    // 2: steps across the wrap point, forward then reverse
    do_reset();
    for (int k = 0; k < 8; k++) send((32'hF000 + k * 32'h2000) % 65536, 1'b0, 0);
    for (int k = 1; k <= 4; k++) send(((32'hF000 + 7 * 32'h2000) - k * 32'h2000 + 65536 * 4) % 65536, 1'b0, 0);
    repeat (4) @(negedge clk);
    check("t2_forward", got_data[1], 32'h0000_1000);
    check("t2_reverse", got_data[2], 32'hFFFF_F000);
    flush("t2");

    // 3: random stream with a 10-cycle downstream stall
    do_reset();
    for (int k = 0; k < 8; k++) send($urandom_range(0, 65535), 1'b0, $urandom_range(0, 2));
    fork
      begin
        for (int k = 0; k < 12; k++) send($urandom_range(0, 65535), 1'b0, 0);
      end
      begin
        logic [31:0] held;
        bit          hv;
        hv = 0;
        held = '0;
        @(posedge clk);
        #1 m_tready = 1'b0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (m_tvalid) begin
            check("t3_stall_sready", 32'(s_tready), 32'd0);
            if (hv) check("t3_hold_data", m_tdata, held);
            held = m_tdata;
            hv = 1;
          end
        end
        @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join
    flush("t3");

    // 4: early tlast closes a partial group
    do_reset();
    for (int k = 0; k < 4; k++) send(k * 32'h1000, 1'b0, 0);
    send(32'h4000, 1'b0, 0);
    send(32'h5000, 1'b1, 0);
    for (int k = 6; k < 10; k++) send(k * 32'h1000, 1'b0, 0);
    repeat (4) @(negedge clk);
    check("t4_partial", got_data[1], 32'h0000_0400);
    check("t4_partial_last", 32'(got_last[1]), 32'd1);
    check("t4_next_group", got_data[2], 32'h0000_0800);
    flush("t4");

    // 5: RAMP, mid-group switch, RAW_ANGLE, DISCRIM_ALT
    do_reset();
    mode = 2'd2;
    for (int k = 0; k < 10; k++) send($urandom_range(0, 65535), 1'b0, 0);
    mode = 2'd0;
    for (int k = 0; k < 6; k++) send($urandom_range(0, 65535), 1'b0, 0);
    mode = 2'd1;
    for (int k = 0; k < 4; k++) send($urandom_range(0, 65535), 1'b0, 0);
    mode = 2'd3;
    for (int k = 0; k < 4; k++) send($urandom_range(0, 65535), k == 2, 0);
    repeat (4) @(negedge clk);
    check("t5_ramp0", got_data[0], 32'd0);
    check("t5_ramp1", got_data[1], 32'd1);
    check("t5_ramp_persist", got_data[2], 32'd2);
    flush("t5");
    mode = 2'd0;

    // 6a: async reset while the output register is full
    do_reset();
    m_tready = 1'b0;
    for (int k = 0; k < 4; k++) send($urandom_range(0, 65535), 1'b0, 0);
    check("t6_full", 32'(m_tvalid), 32'd1);
    check("t6_full_sready", 32'(s_tready), 32'd0);
    check("t6_held_data", m_tdata, exp_data.pop_front());
    void'(exp_last.pop_front());
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_tvalid", 32'(m_tvalid), 32'd0);
    check("t6_async_tdata", m_tdata, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 m_tready = 1'b1;
    @(negedge clk);

    // 6b: reset mid-group with an input beat presented
    for (int k = 0; k < 2; k++) send($urandom_range(0, 65535), 1'b0, 0);
    s_tdata  = 32'($urandom);
    s_tvalid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t6b_tvalid", 32'(m_tvalid), 32'd0);
    model_reset();
    s_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) send($urandom_range(0, 65535), 1'b0, $urandom_range(0, 1));
    flush("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
